vga_timing_anim_gen: RTL and testbench
======================================

// Module: vga_timing_anim_gen
// PURPOSE
//   Upstream stage of every sprite/background renderer: generates 640x480@60 VGA timing from vga_clk
//   (25 MHz), drives DrawX/DrawY/blank consumed by the ROM-addressing renderers, hs/vs to the DAC.
//   Also produces a one-cycle frame_start pulse and a free-running animation frame index that
//   sprite muxes (e.g. right1/right2 walk frames) use to select the active sprite ROM.
// PARAMETERS
//   H_VISIBLE    640  visible pixels per line
//   H_FP         16   horizontal front porch (pixels)
//   H_SYNC       96   horizontal sync width (pixels)
//   H_BP         48   horizontal back porch (pixels); H_TOTAL = sum = 800
//   V_VISIBLE    480  visible lines per frame
//   V_FP         10   vertical front porch (lines)
//   V_SYNC       2    vertical sync width (lines)
//   V_BP         33   vertical back porch (lines); V_TOTAL = sum = 525
//   ANIM_DIV     8    frames per animation step (>=1)
//   ANIM_FRAMES  4    number of animation frames (>=2); AW = $clog2(ANIM_FRAMES)
// PORTS
//   vga_clk      in   1      pixel clock; the single clock of the block
//   reset_n      in   1      asynchronous, active-low reset
//   hs           out  1      horizontal sync, active low
//   vs           out  1      vertical sync, active low
//   blank        out  1      1 = visible pixel (renderers drive colour only when high), 0 = blanking
//   DrawX        out  10     current horizontal count 0..H_TOTAL-1
//   DrawY        out  10     current vertical count 0..V_TOTAL-1
//   frame_start  out  1      one-cycle pulse on the cycle DrawX/DrawY return to (0,0)
//   anim_frame   out  AW     animation frame index 0..ANIM_FRAMES-1
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low.
//   Reset (reset_n=0, immediate, independent of vga_clk): DrawX=0, DrawY=0, hs=1, vs=1, blank=1,
//     frame_start=0, anim_frame=0, internal frame divider=0. First rising edge after release advances.
//   Counters: DrawX increments every cycle; at H_TOTAL-1 wraps to 0 and DrawY increments;
//     DrawY at V_TOTAL-1 with DrawX at H_TOTAL-1 wraps to 0. No other values ever reachable.
//   All outputs are registers. hs/vs/blank are computed from the next-state counters so they are
//     cycle-aligned with the DrawX/DrawY they describe (zero relative latency, glitch-free).
//   hs=0 iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (656..751).
//   vs=0 iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (490..491), for whole lines.
//   blank=1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
//   frame_start=1 for exactly the cycle with DrawX=0, DrawY=0 reached by wrap from
//     (H_TOTAL-1,V_TOTAL-1); NOT asserted in the (0,0) state held/entered by reset.
//   Animation: divider counts frame_start pulses 0..ANIM_DIV-1; on the pulse where divider is
//     ANIM_DIV-1 it clears to 0 and anim_frame increments, wrapping ANIM_FRAMES-1 -> 0.
//     anim_frame changes on the same edge that raises frame_start (changes only during (0,0)
//     onset, never mid-frame). ANIM_DIV=1: anim_frame steps every frame.
//   Reset asserted mid-frame: all state returns to reset values at once; a partial frame never
//     produces a frame_start and never advances the divider.
// TESTING
//   1 Reset: hold reset_n=0 10 cycles -> DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_start=0, anim_frame=0.
//   2 Line: release reset, run 800 cycles -> hs low exactly DrawX 656..751 (96 cycles), blank high
//     DrawX 0..639 on line 0, DrawY becomes 1 on cycle 800.
//   3 Frame: run 2 full frames -> frame_start pulses exactly 420000 cycles apart, vs low for
//     exactly 1600 cycles (DrawY 490..491), blank high 307200 cycles per frame, first pulse after
//     420000 cycles from release.
//   4 Animation: run 33 frames default params -> anim_frame 0->1 at frame_start #8, ->2 at #16,
//     ->3 at #24, wraps ->0 at #32; constant between steps.
//   5 Reset mid-op: assert reset_n=0 asynchronously at DrawX=300, DrawY=200, anim_frame=2 ->
//     outputs at reset values before next edge; after release next frame_start after 420000 cycles.
//   6 Params: ANIM_DIV=1, ANIM_FRAMES=2 -> anim_frame toggles on every frame_start.

Source files
------------

// File: rtl/vga_timing_anim_gen.sv
// 640x480@60 VGA timing generator with a frame-start strobe and a free-running
// animation frame index used by the sprite ROM muxes.
module vga_timing_anim_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int ANIM_DIV    = 8,
    parameter int ANIM_FRAMES = 4
) (
    input  logic                           vga_clk,
    input  logic                           reset_n,
    output logic                           hs,
    output logic                           vs,
    output logic                           blank,
    output logic [9:0]                     DrawX,
    output logic [9:0]                     DrawY,
    output logic                           frame_start,
    output logic [$clog2(ANIM_FRAMES)-1:0] anim_frame
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int AW      = $clog2(ANIM_FRAMES);
    localparam int DW      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_VIS     = 10'(H_VISIBLE);
    localparam logic [9:0]    V_VIS     = 10'(V_VISIBLE);
    localparam logic [9:0]    HS_START  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0]    HS_END    = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0]    VS_START  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]    VS_END    = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [DW-1:0] DIV_LAST  = DW'(ANIM_DIV - 1);
    localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_FRAMES - 1);

    logic [9:0]    r_x;
    logic [9:0]    r_y;
    logic          r_hs;
    logic          r_vs;
    logic          r_blank;
    logic          r_fs;
    logic [DW-1:0] r_div;
    logic [AW-1:0] r_anim;

    logic [9:0]    w_x_nxt;
    logic [9:0]    w_y_nxt;
    logic          w_x_last;
    logic          w_y_last;
    logic          w_wrap;
    logic          w_hs_nxt;
    logic          w_vs_nxt;
    logic          w_blank_nxt;

    // Sync/blank are decoded from the next-state counters so the registered
    // outputs line up with the DrawX/DrawY they describe.
    always_comb begin
        w_x_last    = (r_x == H_LAST);
        w_y_last    = (r_y == V_LAST);
        w_wrap      = w_x_last && w_y_last;
        w_x_nxt     = w_x_last ? 10'd0 : r_x + 10'd1;
        w_y_nxt     = r_y;
        if (w_x_last) begin
            w_y_nxt = w_y_last ? 10'd0 : r_y + 10'd1;
        end
        w_hs_nxt    = !((w_x_nxt >= HS_START) && (w_x_nxt < HS_END));
        w_vs_nxt    = !((w_y_nxt >= VS_START) && (w_y_nxt < VS_END));
        w_blank_nxt = (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x     <= 10'd0;
            r_y     <= 10'd0;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_blank <= 1'b1;
            r_fs    <= 1'b0;
        end else begin
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_hs    <= w_hs_nxt;
            r_vs    <= w_vs_nxt;
            r_blank <= w_blank_nxt;
            r_fs    <= w_wrap;
        end
    end

    // Animation advances on the same edge that raises frame_start, so the
    // sprite select never changes mid-frame.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div  <= '0;
            r_anim <= '0;
        end else if (w_wrap) begin
            if (r_div == DIV_LAST) begin
                r_div  <= '0;
                r_anim <= (r_anim == ANIM_LAST) ? '0 : r_anim + 1'b1;
            end else begin
                r_div  <= r_div + 1'b1;
            end
        end
    end

    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank       = r_blank;
    assign frame_start = r_fs;
    assign anim_frame  = r_anim;

endmodule

// File: tb/tb_vga_timing_anim_gen.sv
// Directed bench: full-size instance for reset/line timing, shrunken-timing
// instances for whole-frame, animation and mid-frame reset behaviour.
`timescale 1ns/1ps
module tb_vga_timing_anim_gen;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 vga_clk = ~vga_clk;

    logic       d_hs, d_vs, d_blank, d_fs;
    logic [9:0] d_x, d_y;
    logic [1:0] d_anim;
    logic       s_hs, s_vs, s_blank, s_fs;
    logic [9:0] s_x, s_y;
    logic [1:0] s_anim;
    logic       p_hs, p_vs, p_blank, p_fs;
    logic [9:0] p_x, p_y;
    logic [0:0] p_anim;

    vga_timing_anim_gen u_def (
        .vga_clk(vga_clk), .reset_n(reset_n), .hs(d_hs), .vs(d_vs), .blank(d_blank),
        .DrawX(d_x), .DrawY(d_y), .frame_start(d_fs), .anim_frame(d_anim)
    );

    // 16x10 total, 8x6 visible: hs low x=10..12, vs low y=7..8, 160 cycles/frame
    vga_timing_anim_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .ANIM_DIV(8), .ANIM_FRAMES(4)
    ) u_sml (
        .vga_clk(vga_clk), .reset_n(reset_n), .hs(s_hs), .vs(s_vs), .blank(s_blank),
        .DrawX(s_x), .DrawY(s_y), .frame_start(s_fs), .anim_frame(s_anim)
    );

    vga_timing_anim_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .ANIM_DIV(1), .ANIM_FRAMES(2)
    ) u_p (
        .vga_clk(vga_clk), .reset_n(reset_n), .hs(p_hs), .vs(p_vs), .blank(p_blank),
        .DrawX(p_x), .DrawY(p_y), .frame_start(p_fs), .anim_frame(p_anim)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        @(negedge vga_clk);
    endtask

    // Leaves the bench on a negedge with reset released and no edge taken yet.
    task automatic do_reset();
        @(negedge vga_clk);
        reset_n = 1'b0;
        repeat (3) @(negedge vga_clk);
        reset_n = 1'b1;
    endtask

    int hs_lo, hs_min, hs_max, blk, xbad, vs_lo, vs_bad, fs_cnt, fs1, fs2, fs_pos_bad, d_fs_cnt;
    int pulses, anim_bad, p_bad, mid_chg, chg, prev_anim, prev_p;
    int a_at[0:40];

    initial begin
        // Reset held for 10 cycles
        reset_n = 1'b0;
        repeat (10) @(posedge vga_clk);
        @(negedge vga_clk);
        chk("rst_DrawX", int'(d_x), 0);
        chk("rst_DrawY", int'(d_y), 0);
        chk("rst_hs", int'(d_hs), 1);
        chk("rst_vs", int'(d_vs), 1);
        chk("rst_blank", int'(d_blank), 1);
        chk("rst_frame_start", int'(d_fs), 0);
        chk("rst_anim", int'(d_anim), 0);

        // One full line on the 640x480 instance
        do_reset();
        hs_lo = 0; hs_min = 9999; hs_max = -1; blk = 0; xbad = 0;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) step();
            if (int'(d_x) != i || d_y != 10'd0) xbad++;
            if (!d_hs) begin
                hs_lo++;
                if (i < hs_min) hs_min = i;
                if (i > hs_max) hs_max = i;
            end
            if (d_blank) blk++;
        end
        chk("line_count_seq", xbad, 0);
        chk("line_hs_low_cycles", hs_lo, 96);
        chk("line_hs_first", hs_min, 656);
        chk("line_hs_last", hs_max, 751);
        chk("line_blank_cycles", blk, 640);
        step();
        chk("line_wrap_DrawX", int'(d_x), 0);
        chk("line_wrap_DrawY", int'(d_y), 1);
        chk("line_wrap_blank", int'(d_blank), 1);

        // Two full frames on the reduced-timing instance
        do_reset();
        fs_cnt = 0; fs1 = -1; fs2 = -1; vs_lo = 0; vs_bad = 0; blk = 0; hs_lo = 0;
        fs_pos_bad = 0; d_fs_cnt = 0;
        for (int e = 1; e <= 320; e++) begin
            step();
            if (s_fs) begin
                fs_cnt++;
                if (fs1 < 0) fs1 = e; else fs2 = e;
                if (s_x != 10'd0 || s_y != 10'd0) fs_pos_bad++;
            end
            if (d_fs) d_fs_cnt++;
            if (!s_vs) vs_lo++;
            if ((!s_vs) != (s_y == 10'd7 || s_y == 10'd8)) vs_bad++;
            if (s_blank) blk++;
            if (!s_hs) hs_lo++;
        end
        chk("frame_pulses", fs_cnt, 2);
        chk("frame_first_pulse", fs1, 160);
        chk("frame_pulse_spacing", fs2 - fs1, 160);
        chk("frame_pulse_at_origin", fs_pos_bad, 0);
        chk("frame_vs_low_cycles", vs_lo, 64);
        chk("frame_vs_rows", vs_bad, 0);
        chk("frame_blank_cycles", blk, 96);
        chk("frame_hs_low_cycles", hs_lo, 60);
        chk("frame_full_size_no_pulse", d_fs_cnt, 0);

        // 33 frames of animation, ANIM_DIV=8/4 frames and ANIM_DIV=1/2 frames
        do_reset();
        pulses = 0; anim_bad = 0; p_bad = 0; mid_chg = 0; chg = 0; prev_anim = 0; prev_p = 0;
        for (int e = 1; e <= 33 * 160; e++) begin
            step();
            if (s_fs) begin
                pulses++;
                if (pulses <= 40) a_at[pulses] = int'(s_anim);
                if (int'(s_anim) != (pulses / 8) % 4) anim_bad++;
                if (int'(p_anim) != pulses % 2) p_bad++;
            end else begin
                if (int'(s_anim) != prev_anim) mid_chg++;
                if (int'(p_anim) != prev_p) mid_chg++;
            end
            if (int'(s_anim) != prev_anim) chg++;
            prev_anim = int'(s_anim);
            prev_p    = int'(p_anim);
        end
        chk("anim_pulses", pulses, 33);
        chk("anim_at_pulse7", a_at[7], 0);
        chk("anim_at_pulse8", a_at[8], 1);
        chk("anim_at_pulse16", a_at[16], 2);
        chk("anim_at_pulse24", a_at[24], 3);
        chk("anim_at_pulse31", a_at[31], 3);
        chk("anim_at_pulse32", a_at[32], 0);
        chk("anim_sequence", anim_bad, 0);
        chk("anim_changes", chg, 4);
        chk("anim_mid_frame_changes", mid_chg, 0);
        chk("anim_div1_toggle", p_bad, 0);

        // Asynchronous reset mid-frame at (11,7) of frame 17 (anim=2, hs/vs low)
        do_reset();
        repeat (17 * 160 + 7 * 16 + 11) step();
        chk("mid_DrawX", int'(s_x), 11);
        chk("mid_DrawY", int'(s_y), 7);
        chk("mid_anim", int'(s_anim), 2);
        chk("mid_hs", int'(s_hs), 0);
        chk("mid_vs", int'(s_vs), 0);
        chk("mid_blank", int'(s_blank), 0);
        #1 reset_n = 1'b0;
        #1;
        chk("async_DrawX", int'(s_x), 0);
        chk("async_DrawY", int'(s_y), 0);
        chk("async_hs", int'(s_hs), 1);
        chk("async_vs", int'(s_vs), 1);
        chk("async_blank", int'(s_blank), 1);
        chk("async_frame_start", int'(s_fs), 0);
        chk("async_anim", int'(s_anim), 0);
        chk("async_full_DrawX", int'(d_x), 0);
        repeat (2) @(negedge vga_clk);
        chk("held_frame_start", int'(s_fs), 0);
        reset_n = 1'b1;
        pulses = 0; fs1 = -1;
        for (int e = 1; e <= 8 * 160; e++) begin
            step();
            if (s_fs) begin
                pulses++;
                if (fs1 < 0) fs1 = e;
                if (pulses <= 40) a_at[pulses] = int'(s_anim);
            end
        end
        chk("post_rst_first_pulse", fs1, 160);
        chk("post_rst_pulses", pulses, 8);
        chk("post_rst_anim_pulse7", a_at[7], 0);
        chk("post_rst_anim_pulse8", a_at[8], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
